// File: rtl/chan_mode_pipe_pkg.sv
// Shared types and the per-lane transform for chan_mode_pipe.
//   mode_t     : 2-bit per-channel transform mode.
//   lane_t     : widest lane the transform helper handles (LANE_MAX_W bits).
//   apply_mode : returns the transformed lane for a given mode, input and hold value.
package chan_mode_pkg;

  // Lanes wider than this are not supported by apply_mode.
  localparam int LANE_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_ZERO   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef logic [LANE_MAX_W-1:0] lane_t;

  // Callers zero-extend narrower lanes into lane_t and truncate the result
  // back; inverting the extension bits is harmless because they are dropped.
  function automatic lane_t apply_mode(input mode_t mode, input lane_t data,
                                       input lane_t hold);
    lane_t res;
    case (mode)
      MODE_PASS:   res = data;
      MODE_INVERT: res = ~data;
      MODE_ZERO:   res = '0;
      MODE_HOLD:   res = hold;
      default:     res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/chan_mode_pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer: one output register plus one skid register.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : producer handshake; in_ready is registered (!skid full)
//   in_data             : beat to store
//   out_valid/out_ready : consumer handshake
//   out_data            : output register contents, stable while stalled
module skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             accept, present;

  assign accept  = in_valid && ready_q;
  assign present = out_valid_q && out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (present) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // An accept only happens with the skid empty (ready_q tracks !skid_full).
    // It lands in the output register if that is empty or draining this edge.
    if (accept) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end

    ready_d = !skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // Data registers are reset too so out_data reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/chan_mode_pipe.sv
// Multi-channel mode pipe: applies a runtime-programmable transform to each of
// CHANNELS lanes and passes the beat through a skid-buffered valid/ready stage.
//   clk, rst_n                   : clock, async active-low reset
//   cfg_we, cfg_chan, cfg_mode   : mode write port (cfg_chan >= CHANNELS ignored)
//   mode_q                       : current modes, lane c at [2c+1:2c]
//   in_valid, in_ready, in_data  : producer stream, lane c at [c*WIDTH +: WIDTH]
//   out_valid, out_ready, out_data : consumer stream, same packing, latency 1
module chan_mode_pipe
  import chan_mode_pkg::*;
#(
  parameter int    WIDTH        = 8,
  parameter int    CHANNELS     = 4,
  parameter mode_t DEFAULT_MODE = MODE_PASS,
  localparam int   CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [CHAN_W-1:0]         cfg_chan,
  input  logic [1:0]                cfg_mode,
  output logic [2*CHANNELS-1:0]     mode_q,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
);

  logic                      accept;
  logic [CHANNELS*WIDTH-1:0] xform_data;

  assign accept = in_valid && in_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mode_t            mode_lane_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] lane_xf;

    // Uses the mode from before any same-cycle cfg write, so a write never
    // affects the beat accepted on the same edge.
    assign lane_xf = WIDTH'(apply_mode(mode_lane_q,
                                       lane_t'(in_data[c*WIDTH +: WIDTH]),
                                       lane_t'(hold_q)));

    // In HOLD mode lane_xf equals hold_q, so the register keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else if (accept) begin
        hold_q <= lane_xf;
      end
    end

    // Out-of-range cfg_chan values match no lane and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_lane_q <= DEFAULT_MODE;
      end else if (cfg_we && (cfg_chan == CHAN_W'(c))) begin
        mode_lane_q <= mode_t'(cfg_mode);
      end
    end

    assign mode_q[2*c +: 2]               = mode_lane_q;
    assign xform_data[c*WIDTH +: WIDTH]   = lane_xf;
  end

  skid_buf #(
    .WIDTH(CHANNELS * WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (xform_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: doc/chan_mode_pipe.md
Name: chan_mode_pipe

Overview:
- Registered, multi-channel successor to the single-bit mode selector.
- Passes CHANNELS lanes of WIDTH bits through a valid/ready pipeline stage with a 2-entry skid buffer.
- Applies a per-channel transform mode to each lane. Modes are runtime-programmable through a config write port; reset loads the parameter default.
- Sits between a producer and a consumer stream; full throughput, 1-cycle latency.

Parameters:
- WIDTH, 8, bits per channel lane (≥1).
- CHANNELS, 4, number of lanes (≥1).
- DEFAULT_MODE, 2'd0, mode loaded into every channel at reset.
- CHAN_W, max(1,$clog2(CHANNELS)), derived (localparam); width of cfg_chan.

Ports:
- clk  in  1  Single clock; all state on rising edge.
- rst_n  in  1  Reset, asynchronous assert, active-low.
- cfg_we  in  1  Write cfg_mode into channel cfg_chan this cycle.
- cfg_chan  in  CHAN_W  Target channel; values ≥ CHANNELS are ignored (no write).
- cfg_mode  in  2  0 PASS, 1 INVERT, 2 ZERO, 3 HOLD.
- mode_q  out  2*CHANNELS  Current mode per channel; lane c at [2c+1:2c].
- in_valid  in  1  Producer beat valid.
- in_ready  out  1  Block can accept a beat.
- in_data  in  CHANNELS*WIDTH  Lane c at [c*WIDTH +: WIDTH].
- out_valid  out  1  Output beat valid.
- out_ready  in  1  Consumer accepts beat.
- out_data  out  CHANNELS*WIDTH  Transformed beat, same lane packing.

Behaviour:
- Reset (rst_n low, async):
  - mode_q = DEFAULT_MODE in every lane.
  - out_valid = 0, out_data = 0, skid empty.
  - in_ready = 0 while reset is asserted; in_ready = 1 from the first cycle after release.
  - Hold registers = 0.
  - Reset mid-stream discards all buffered beats; no partial beat is emitted.
- Accept / present:
  - Accept occurs when in_valid && in_ready.
  - Present occurs when out_valid && out_ready.
- Transform, evaluated at accept time using the mode_q value before any same-cycle cfg write:
  - PASS: lane = in.
  - INVERT: lane = ~in (bitwise).
  - ZERO: lane = 0.
  - HOLD: lane = that lane's hold register; the input lane is ignored.
  - Every accept stores each lane's transformed value into that lane's hold register. In HOLD mode this leaves the register unchanged.
- Buffering: output register plus one skid register.
  - Output register empty: the accepted beat goes to the output register; out_valid rises the next cycle (latency 1).
  - Output register full and not presented: the accepted beat goes to the skid register; in_ready = 0 the next cycle.
  - Present with skid full: the skid moves to the output register the same edge; in_ready returns to 1 the next cycle.
  - Simultaneous accept and present with skid empty: the output register is replaced by the new beat; out_valid stays 1.
  - in_ready = !skid_full, registered; it does not depend combinationally on out_ready.
  - Sustained in_valid and out_ready gives 1 beat per cycle, with no bubbles.
- Ordering: beats are strictly in order, with no drop and no duplication.
- Config:
  - A cfg write updates mode_q on the next edge.
  - A write in the same cycle as an accept does not affect that beat; it affects the next accept.
  - Beats already buffered keep the mode they were transformed with.
- out_data is held stable while out_valid && !out_ready.
- CHANNELS=1: cfg_chan is 1 bit; value 1 is ignored.

Decomposition:
- Package chan_mode_pkg:
  - enum mode_t {MODE_PASS=0, MODE_INVERT=1, MODE_ZERO=2, MODE_HOLD=3}.
  - Function apply_mode(mode, data, hold), returning the transformed lane.
- Sub-module skid_buf (WIDTH parameter): the generic 2-entry valid/ready skid register.
- chan_mode_pipe instantiates one skid_buf of width CHANNELS*WIDTH. The transform and hold registers are a generate loop over channels.

Test Plan:
- Reset defaults: DEFAULT_MODE=0, CHANNELS=4, WIDTH=8. Release reset, send in_data=0x12345678 with out_ready=1 → out_data=0x12345678 one cycle later; mode_q=0x00.
- Per-lane modes: cfg lane0=INVERT, lane1=ZERO, lane2=HOLD (hold register = 0x34 from the previous beat), lane3=PASS. Send 0xAABBCCDD → out_data=0xAA340022.
- Backpressure: out_ready=0 and stream 3 beats (0x01, 0x02, 0x03 in lane0) → in_ready drops after the 2nd accept. Raise out_ready → outputs 0x01, 0x02, 0x03 in order, none lost.
- Same-cycle config: cfg_we lane0=INVERT in the same cycle as accepting 0x0F → output lane0=0x0F; the next beat 0x0F → 0xF0.
- Mid-stream reset: assert rst_n=0 with 2 beats buffered → out_valid=0 immediately (async), mode_q=DEFAULT_MODE, and no stale beat appears after release.
- Invalid channel: cfg_we with cfg_chan=5 when CHANNELS=4 → mode_q unchanged.
